// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the transmitter, receiver and register block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic [1:0] DBN_5 = 2'b00;
  localparam logic [1:0] DBN_6 = 2'b01;
  localparam logic [1:0] DBN_7 = 2'b10;
  localparam logic [1:0] DBN_8 = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Payload and framing captured at launch so mid-frame register writes are harmless.
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] dbn;
    logic       two_stop;
    logic       par_en;
    logic       par_type;
  } uart_tx_frame_t;

  // Number of data bits for a data_bit_num encoding.
  function automatic logic [3:0] dbn_to_len(input logic [1:0] dbn);
    case (dbn)
      DBN_5:   return 4'd5;
      DBN_6:   return 4'd6;
      DBN_7:   return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_gen.sv
// Baud down-counter: load restarts a bit period, tick_o pulses for one clock at period end.
module uart_baud_gen #(
  parameter int unsigned DIV = 434,
  parameter int unsigned W   = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  logic [W-1:0] cnt_q;
  logic         tick_q;
  logic         tick_d;

  // The tick is registered: it is raised on the edge where the count reaches zero.
  assign tick_d = en_i && !load_i && (cnt_q == W'(1));
  assign tick_o = tick_q;

  // Count down from DIV-1, reloading at zero so every period is exactly DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      if (load_i) begin
        cnt_q <= W'(DIV - 1);
      end else if (en_i) begin
        if (cnt_q == '0) cnt_q <= W'(DIV - 1);
        else             cnt_q <= cnt_q - W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Optional feature: define UART_TX_BREAK_EN to add the send_break input (line held low in IDLE).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned DIV_W    = $clog2(BAUD_DIV)
) (
  input  logic       clk,
  input  logic       rst,
`ifdef UART_TX_BREAK_EN
  input  logic       send_break,
`endif
  input  logic [7:0] tx_data,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       start_tx,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_serializer: BAUD_DIV must be at least 2");
  end

  uart_tx_state_t state_q;
  uart_tx_frame_t shadow_q;
  logic [2:0]     bit_idx_q;
  logic           start_q;
  logic           tx_q;
  logic           busy_q;
  logic           done_q;

  logic           brk_c;
  logic           launch_c;
  logic           tick_c;
  logic [3:0]     len_c;
  logic [7:0]     mask_c;
  logic           parity_c;
  logic [2:0]     next_idx_c;
  logic           last_data_c;

`ifdef UART_TX_BREAK_EN
  assign brk_c = send_break;
`else
  assign brk_c = 1'b0;
`endif

  // A launch needs a fresh 0->1 on start_tx while idle and not sending a break.
  assign launch_c = (state_q == IDLE) && start_tx && !start_q && !brk_c;

  // Frame helpers derived from the shadow copy.
  assign len_c       = dbn_to_len(shadow_q.dbn);
  assign mask_c      = 8'hFF >> (4'd8 - len_c);
  assign parity_c    = (^(shadow_q.data & mask_c)) ^ (shadow_q.par_type == PAR_ODD);
  assign next_idx_c  = bit_idx_q + 3'd1;
  assign last_data_c = (bit_idx_q == 3'(len_c - 4'd1));

  uart_baud_gen #(
    .DIV (BAUD_DIV),
    .W   (DIV_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .load_i (launch_c),
    .en_i   (busy_q),
    .tick_o (tick_c)
  );

  // Frame sequencer with registered line, busy and sticky done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      bit_idx_q <= '0;
      start_q   <= 1'b1;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q <= start_tx;
      case (state_q)
        IDLE: begin
          if (launch_c) begin
            shadow_q  <= '{data: tx_data, dbn: data_bit_num, two_stop: stop_bit_num,
                           par_en: parity_en, par_type: parity_type};
            state_q   <= START;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end else begin
            tx_q <= !brk_c;
          end
        end
        START: begin
          if (tick_c) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= shadow_q.data[0];
          end
        end
        DATA: begin
          if (tick_c) begin
            if (!last_data_c) begin
              bit_idx_q <= next_idx_c;
              tx_q      <= shadow_q.data[next_idx_c];
            end else if (shadow_q.par_en) begin
              state_q <= PARITY;
              tx_q    <= parity_c;
            end else begin
              state_q   <= STOP;
              bit_idx_q <= '0;
              tx_q      <= 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick_c) begin
            state_q   <= STOP;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
          end
        end
        STOP: begin
          if (tick_c) begin
            if (shadow_q.two_stop && (bit_idx_q == 3'd0)) begin
              bit_idx_q <= 3'd1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            tx_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with BAUD_DIV=4.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int unsigned BD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       start_tx;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
`ifdef UART_TX_BREAK_EN
  logic       send_break;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_serializer #(.BAUD_DIV(BD)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef UART_TX_BREAK_EN
    .send_break   (send_break),
`endif
    .tx_data      (tx_data),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .start_tx     (start_tx),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk({tag, "_tx"}, tx, 1'b1);
      chk({tag, "_busy"}, tx_busy, 1'b0);
      chk({tag, "_done"}, tx_done, exp_done);
      step();
    end
  endtask

  // exp holds the transmitted bits in line order (bit 0 = start bit).
  // mode 0: drop start_tx after launch; mode 2: drop it, then raise and hold it mid-frame.
  task automatic send_frame(input string tag, input logic [11:0] exp, input int n, input int mode);
    logic [11:0] e;
    e = exp;
    start_tx = 1'b1;
    step();
    start_tx = 1'b0;
    // Scramble the live inputs: the frame must come from the launch-time copy.
    tx_data      = ~tx_data;
    data_bit_num = ~data_bit_num;
    parity_en    = ~parity_en;
    parity_type  = ~parity_type;
    stop_bit_num = ~stop_bit_num;
    for (int c = 0; c < n * int'(BD); c++) begin
      if (mode == 2 && c == 12) start_tx = 1'b1;
      chk({tag, "_tx"}, tx, e[c / int'(BD)]);
      chk({tag, "_busy"}, tx_busy, 1'b1);
      chk({tag, "_done"}, tx_done, 1'b0);
      step();
    end
    chk({tag, "_end_tx"}, tx, 1'b1);
    chk({tag, "_end_busy"}, tx_busy, 1'b0);
    chk({tag, "_end_done"}, tx_done, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    tx_data      = 8'h00;
    data_bit_num = DBN_8;
    stop_bit_num = 1'b0;
    parity_en    = 1'b0;
    parity_type  = PAR_EVEN;
    start_tx     = 1'b1;
`ifdef UART_TX_BREAK_EN
    send_break   = 1'b0;
`endif
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_done", tx_done, 1'b0);
    step();
    step();
    rst = 1'b0;
    // start_tx already high out of reset must not launch.
    chk_idle("rel_hi", 1'b0, 8);
    start_tx = 1'b0;
    step();

    // 1: 0x55 8N1 -> 10 bits, 40 clocks
    tx_data = 8'h55; data_bit_num = DBN_8; parity_en = 1'b0; stop_bit_num = 1'b0;
    send_frame("f55_8n1", 12'b00_1_01010101_0, 10, 0);
    chk_idle("post1", 1'b1, 3);

    // 2: 0x0F 7E2 -> data 1111000, parity 0, two stops: 11 bits, 44 clocks
    tx_data = 8'h0F; data_bit_num = DBN_7; parity_en = 1'b1; parity_type = PAR_EVEN;
    stop_bit_num = 1'b1;
    send_frame("f0f_7e2", 12'b0_11_0_0001111_0, 11, 0);

    // 3: 0x03 5O1 -> data 11000, parity 1: 8 bits, 32 clocks (launched back-to-back)
    tx_data = 8'h03; data_bit_num = DBN_5; parity_en = 1'b1; parity_type = PAR_ODD;
    stop_bit_num = 1'b0;
    send_frame("f03_5o1", 12'b0000_1_1_00011_0, 8, 0);
    tx_data = 8'h03; data_bit_num = DBN_5; parity_en = 1'b1; parity_type = PAR_EVEN;
    stop_bit_num = 1'b0;
    send_frame("f03_5e1", 12'b0000_1_0_00011_0, 8, 0);

    // 4: start_tx raised mid-frame and held past the end -> no second frame
    tx_data = 8'hA6; data_bit_num = DBN_6; parity_en = 1'b0; stop_bit_num = 1'b0;
    send_frame("f26_6n1", 12'b0000_1_100110_0, 8, 2);
    chk_idle("held_hi", 1'b1, 12);
    start_tx = 1'b0;
    step();
    tx_data = 8'h55; data_bit_num = DBN_8; parity_en = 1'b0; stop_bit_num = 1'b0;
    send_frame("relaunch", 12'b00_1_01010101_0, 10, 0);

    // 5: reset during DATA with start_tx held high
    tx_data = 8'h00; data_bit_num = DBN_8; parity_en = 1'b0; stop_bit_num = 1'b0;
    start_tx = 1'b1;
    step();
    chk("abort_launch_tx", tx, 1'b0);
    repeat (6) step();
    chk("abort_in_data_tx", tx, 1'b0);
    chk("abort_in_data_busy", tx_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_async_tx", tx, 1'b1);
    chk("abort_async_busy", tx_busy, 1'b0);
    chk("abort_async_done", tx_done, 1'b0);
    step();
    rst = 1'b0;
    chk_idle("abort_rel", 1'b0, 12);
    start_tx = 1'b0;
    step();
    tx_data = 8'h55;
    send_frame("after_abort", 12'b00_1_01010101_0, 10, 0);

`ifdef UART_TX_BREAK_EN
    // 6: break holds the line low and blocks launches
    send_break = 1'b1;
    step();
    chk("brk_tx", tx, 1'b0);
    start_tx = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("brk_hold_tx", tx, 1'b0);
      chk("brk_hold_busy", tx_busy, 1'b0);
    end
    send_break = 1'b0;
    step();
    chk("brk_off_tx", tx, 1'b1);
    chk("brk_off_busy", tx_busy, 1'b0);
    start_tx = 1'b0;
    step();
    tx_data = 8'h55; data_bit_num = DBN_8; parity_en = 1'b0; stop_bit_num = 1'b0;
    send_frame("after_brk", 12'b00_1_01010101_0, 10, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
